// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI register bank: FSM states, R/W encoding, frame length.
package spi_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCmd,
        StData,
        StDone
    } spi_state_e;

    localparam logic RW_WRITE = 1'b1;

    function automatic int unsigned frame_len(input int unsigned addr_w, input int unsigned data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin, with level and single-cycle edge outputs.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 target with a R/W register bank and CIPO readback.
// Optional build macro SPI_BURST_EN: multi-word frames with auto-incrementing address.
module spi_reg_bank
    import spi_pkg::*;
#(
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned NUM_REGS    = 5,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ncs,
    input  logic                         sclk,
    input  logic                         copi,
    output logic                         cipo,
    output logic                         cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q,
    output logic [NUM_REGS-1:0]          wr_strobe,
    output logic                         frame_err
);

    localparam int unsigned CNT_W = $clog2(ADDR_W + DATA_W + 1);

    logic ncs_lvl, ncs_rise, ncs_fall;
    logic unused_sclk_lvl, sclk_rise, sclk_fall;
    logic copi_lvl, unused_copi_rise, unused_copi_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .din(ncs),
        .level(ncs_lvl), .rise(ncs_rise), .fall(ncs_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .din(sclk),
        .level(unused_sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .din(copi),
        .level(copi_lvl), .rise(unused_copi_rise), .fall(unused_copi_fall)
    );

    spi_state_e              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic [ADDR_W-1:0]       cmd_sr_q;
    logic [DATA_W-2:0]       data_sr_q;
    logic                    rw_q;
    logic [ADDR_W-1:0]       addr_q;
    logic                    load_q;
    logic                    commit_q;
    logic [ADDR_W-1:0]       commit_addr_q;
    logic [DATA_W-1:0]       commit_data_q;
    logic [DATA_W-1:0]       sout_q;
    logic                    cipo_q;
    logic                    frame_err_q;
    logic [NUM_REGS-1:0]     wr_strobe_q;
    logic [DATA_W-1:0]       regs_q [NUM_REGS];
    logic [DATA_W-1:0]       read_val;

    logic sample, cmd_last, word_last, partial, abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (ncs_fall) state_d = StCmd;
            StCmd:  if (cmd_last) state_d = StData;
`ifdef SPI_BURST_EN
            StData: state_d = StData;
`else
            StData: if (word_last) state_d = StDone;
`endif
            StDone: state_d = StDone;
            default: state_d = StIdle;
        endcase
        // The bit sampled this cycle is folded in above before the abort takes effect.
        if (ncs_rise) state_d = StIdle;
    end

    always_comb begin
        sample    = 1'b0;
        cmd_last  = 1'b0;
        word_last = 1'b0;
        partial   = 1'b0;
        unique case (state_q)
            StCmd: begin
                sample   = sclk_rise;
                cmd_last = sclk_rise && (cnt_q == CNT_W'(ADDR_W));
`ifdef SPI_BURST_EN
                partial  = (cnt_q != '0 || sclk_rise) && !cmd_last;
`else
                partial  = cnt_q != '0 || sclk_rise;
`endif
            end
            StData: begin
                sample    = sclk_rise;
                word_last = sclk_rise && (cnt_q == CNT_W'(DATA_W - 1));
`ifndef SPI_BURST_EN
                partial   = !word_last;
`endif
            end
            default: ;
        endcase
        abort = ncs_rise && partial;
    end

    always_comb begin
        read_val = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (addr_q == ADDR_W'(k)) read_val = regs_q[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            cmd_sr_q      <= '0;
            data_sr_q     <= '0;
            rw_q          <= 1'b0;
            addr_q        <= '0;
            load_q        <= 1'b0;
            commit_q      <= 1'b0;
            commit_addr_q <= '0;
            commit_data_q <= '0;
            sout_q        <= '0;
            cipo_q        <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            load_q      <= 1'b0;
            commit_q    <= 1'b0;
            frame_err_q <= abort;

            if (ncs_rise || state_q == StIdle || cmd_last || word_last) begin
                cnt_q <= '0;
            end else if (sample) begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (sample && state_q == StCmd) cmd_sr_q <= {cmd_sr_q[ADDR_W-2:0], copi_lvl};
            if (sample && state_q == StData) data_sr_q <= {data_sr_q[DATA_W-3:0], copi_lvl};

            if (cmd_last) begin
                rw_q   <= cmd_sr_q[ADDR_W-1];
                addr_q <= {cmd_sr_q[ADDR_W-2:0], copi_lvl};
                load_q <= cmd_sr_q[ADDR_W-1] != RW_WRITE;
            end

            if (word_last) begin
                commit_q      <= (rw_q == RW_WRITE) && (32'(addr_q) < NUM_REGS);
                commit_addr_q <= addr_q;
                commit_data_q <= {data_sr_q, copi_lvl};
`ifdef SPI_BURST_EN
                addr_q        <= addr_q + 1'b1;
                load_q        <= rw_q != RW_WRITE;
`endif
            end

            // The first fall after a load belongs to the previous bit, so it must not shift.
            if (load_q) begin
                sout_q <= read_val;
                cipo_q <= read_val[DATA_W-1];
            end else if (state_q == StData && sclk_fall && cnt_q != '0 && rw_q != RW_WRITE) begin
                sout_q <= sout_q << 1;
                cipo_q <= sout_q[DATA_W-2];
            end
            if (state_d == StIdle || state_d == StDone) cipo_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_strobe_q <= '0;
            for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                wr_strobe_q[k] <= commit_q && (commit_addr_q == ADDR_W'(k));
                if (commit_q && (commit_addr_q == ADDR_W'(k))) regs_q[k] <= commit_data_q;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_REGS; k++) reg_q[k*DATA_W +: DATA_W] = regs_q[k];
    end

    assign cipo      = cipo_q;
    assign cipo_oe   = ~ncs_lvl;
    assign wr_strobe = wr_strobe_q;
    assign frame_err = frame_err_q;

endmodule
